mandelbrot_scheduler: RTL and testbench

MANDELBROT_SCHEDULER -- requirements
Module: mandelbrot_scheduler

---
 rtl/mandelbrot_scheduler_if.sv | 41 ++++
 rtl/mandelbrot_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_mandelbrot_scheduler.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mandelbrot_scheduler_if.sv
// Slot and pixel buses of the Mandelbrot scheduler.
//   loop_*  : slot coming back from the iteration pipeline loopback (into the scheduler)
//   issue_* : slot the scheduler sends back into the pipeline
//   pix_*   : retired-pixel stream, valid/ready handshake
// master = scheduler side, slave = pipeline / pixel-sink side.
interface mandelbrot_scheduler_if #(
    parameter int unsigned IW = 8
);
    logic          loop_valid;
    logic [10:0]   loop_x;
    logic [10:0]   loop_y;
    logic [IW-1:0] loop_iter;
    logic          loop_escape;

    logic          issue_valid;
    logic          issue_new;
    logic          issue_hold;
    logic [10:0]   issue_x;
    logic [10:0]   issue_y;
    logic [IW-1:0] issue_iter;

    logic          pix_valid;
    logic          pix_ready;
    logic [10:0]   pix_x;
    logic [10:0]   pix_y;
    logic [IW-1:0] pix_iter;

    modport master (
        input  loop_valid, loop_x, loop_y, loop_iter, loop_escape,
        output issue_valid, issue_new, issue_hold, issue_x, issue_y, issue_iter,
        output pix_valid, pix_x, pix_y, pix_iter,
        input  pix_ready
    );

    modport slave (
        output loop_valid, loop_x, loop_y, loop_iter, loop_escape,
        input  issue_valid, issue_new, issue_hold, issue_x, issue_y, issue_iter,
        input  pix_valid, pix_x, pix_y, pix_iter,
        output pix_ready
    );
endinterface

// File: rtl/mandelbrot_scheduler.sv
// Mandelbrot frame scheduler.
// Walks the frame in raster order, feeding new pixels into free pipeline slots, recirculating
// unfinished slots with iter+1, and retiring finished slots onto the pixel stream. A finished
// slot that cannot retire because the pixel output is stalled is recirculated unchanged (hold).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start, imax     : begin a frame (IDLE only), iteration limit captured on start
//   busy            : frame in progress (RUN or DRAIN)
//   frame_done      : one-cycle pulse when the frame is complete
//   bus             : loop_* / issue_* / pix_* buses (master side)
module mandelbrot_scheduler #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned IW     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [IW-1:0]                 imax,
    output logic                          busy,
    output logic                          frame_done,
    mandelbrot_scheduler_if.master        bus
);

    localparam int unsigned CntW = $clog2(WIDTH * HEIGHT + 1);
    localparam logic [10:0] XLast = 11'(WIDTH - 1);
    localparam logic [10:0] YLast = 11'(HEIGHT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] imax_q, imax_d;
    logic [10:0]   x_q, x_d;
    logic [10:0]   y_q, y_d;
    logic [CntW-1:0] inflight_q, inflight_d;

    logic          issue_valid_q, issue_valid_d;
    logic          issue_new_q, issue_new_d;
    logic          issue_hold_q, issue_hold_d;
    logic [10:0]   issue_x_q, issue_x_d;
    logic [10:0]   issue_y_q, issue_y_d;
    logic [IW-1:0] issue_iter_q, issue_iter_d;

    logic          pix_valid_q, pix_valid_d;
    logic [10:0]   pix_x_q, pix_x_d;
    logic [10:0]   pix_y_q, pix_y_d;
    logic [IW-1:0] pix_iter_q, pix_iter_d;

    logic active;
    logic slot_valid;
    logic finished;
    logic out_free;
    logic retire;
    logic recirc;
    logic new_issue;
    logic dec;
    logic at_last;

    // Returning slots are only meaningful while a frame is running or draining.
    assign active     = (state_q == StRun) || (state_q == StDrain);
    assign slot_valid = bus.loop_valid && active;
    assign finished   = slot_valid && (bus.loop_escape || (bus.loop_iter >= imax_q));
    assign out_free   = !pix_valid_q || bus.pix_ready;
    assign retire     = finished && out_free;
    assign recirc     = slot_valid && !retire;
    assign new_issue  = (state_q == StRun) && !recirc;
    assign dec        = retire && (inflight_q != '0);
    assign at_last    = (x_q == XLast) && (y_q == YLast);

    always_comb begin
        state_d       = state_q;
        imax_d        = imax_q;
        x_d           = x_q;
        y_d           = y_q;
        inflight_d    = inflight_q;
        issue_valid_d = 1'b0;
        issue_new_d   = 1'b0;
        issue_hold_d  = 1'b0;
        issue_x_d     = issue_x_q;
        issue_y_d     = issue_y_q;
        issue_iter_d  = issue_iter_q;
        pix_valid_d   = pix_valid_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_iter_d    = pix_iter_q;

        // Pixel output register: a fresh retire overrides the handshake clear.
        if (bus.pix_ready) begin
            pix_valid_d = 1'b0;
        end
        if (retire) begin
            pix_valid_d = 1'b1;
            pix_x_d     = bus.loop_x;
            pix_y_d     = bus.loop_y;
            pix_iter_d  = bus.loop_iter;
        end

        // Slot decision: recirculate (hold or iterate), or fill a free slot from the raster.
        if (recirc) begin
            issue_valid_d = 1'b1;
            issue_hold_d  = finished;
            issue_x_d     = bus.loop_x;
            issue_y_d     = bus.loop_y;
            // Unfinished implies loop_iter < imax_q, so +1 cannot wrap.
            issue_iter_d  = finished ? bus.loop_iter : bus.loop_iter + IW'(1);
        end else if (new_issue) begin
            issue_valid_d = 1'b1;
            issue_new_d   = 1'b1;
            issue_x_d     = x_q;
            issue_y_d     = y_q;
            issue_iter_d  = '0;
            if (x_q == XLast) begin
                x_d = '0;
                y_d = y_q + 11'd1;
            end else begin
                x_d = x_q + 11'd1;
            end
        end

        case ({new_issue, dec})
            2'b10:   inflight_d = inflight_q + CntW'(1);
            2'b01:   inflight_d = inflight_q - CntW'(1);
            default: inflight_d = inflight_q;
        endcase

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRun;
                    imax_d     = imax;
                    x_d        = '0;
                    y_d        = '0;
                    inflight_d = '0;
                end
            end
            StRun: begin
                if (new_issue && at_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if ((inflight_q == '0) && !pix_valid_q) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            imax_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            inflight_q    <= '0;
            issue_valid_q <= 1'b0;
            issue_new_q   <= 1'b0;
            issue_hold_q  <= 1'b0;
            issue_x_q     <= '0;
            issue_y_q     <= '0;
            issue_iter_q  <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_iter_q    <= '0;
        end else begin
            state_q       <= state_d;
            imax_q        <= imax_d;
            x_q           <= x_d;
            y_q           <= y_d;
            inflight_q    <= inflight_d;
            issue_valid_q <= issue_valid_d;
            issue_new_q   <= issue_new_d;
            issue_hold_q  <= issue_hold_d;
            issue_x_q     <= issue_x_d;
            issue_y_q     <= issue_y_d;
            issue_iter_q  <= issue_iter_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_iter_q    <= pix_iter_d;
        end
    end

    assign busy       = (state_q == StRun) || (state_q == StDrain);
    assign frame_done = (state_q == StFin);

    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_new   = issue_new_q;
    assign bus.issue_hold  = issue_hold_q;
    assign bus.issue_x     = issue_x_q;
    assign bus.issue_y     = issue_y_q;
    assign bus.issue_iter  = issue_iter_q;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.pix_iter    = pix_iter_q;

endmodule

// File: tb/tb_mandelbrot_scheduler.sv
// Self-checking bench for mandelbrot_scheduler (WIDTH=4, HEIGHT=2, IW=8).
// Retired pixels are checked against a scoreboard queue by a negedge monitor; slot/issue
// behaviour is checked directly from the stimulus thread.
module tb_mandelbrot_scheduler;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned IW = 8;

    typedef struct packed {
        logic [10:0]   x;
        logic [10:0]   y;
        logic [IW-1:0] iter;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [IW-1:0] imax = '0;
    logic          busy;
    logic          frame_done;

    // Ring mode feeds issue_* straight back as loop_* (1-deep loopback).
    logic          ring_en = 1'b0;
    logic          drv_valid = 1'b0;
    logic [10:0]   drv_x = '0;
    logic [10:0]   drv_y = '0;
    logic [IW-1:0] drv_iter = '0;
    logic          drv_esc = 1'b0;
    logic          drv_ready = 1'b0;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   fd_count = 0;
    pix_t exp_q[$];

    mandelbrot_scheduler_if #(.IW(IW)) bus_if ();

    assign bus_if.loop_valid  = ring_en ? bus_if.issue_valid : drv_valid;
    assign bus_if.loop_x      = ring_en ? bus_if.issue_x : drv_x;
    assign bus_if.loop_y      = ring_en ? bus_if.issue_y : drv_y;
    assign bus_if.loop_iter   = ring_en ? bus_if.issue_iter : drv_iter;
    assign bus_if.loop_escape = drv_esc;
    assign bus_if.pix_ready   = drv_ready;

    mandelbrot_scheduler #(.WIDTH(W), .HEIGHT(H), .IW(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imax       (imax),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [IW-1:0] it);
        for (int yy = 0; yy < int'(H); yy++) begin
            for (int xx = 0; xx < int'(W); xx++) begin
                exp_q.push_back('{x: 11'(xx), y: 11'(yy), iter: it});
            end
        end
    endtask

    task automatic wait_frames(input int target, input string name);
        for (int i = 0; i < 400 && fd_count < target; i++) tick();
        check(name, fd_count, target);
    endtask

    // Scoreboard monitor: pops one expected pixel per accepted transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) fd_count++;
            if (bus_if.pix_valid && bus_if.pix_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pix_unexpected: got (%0d,%0d,%0d) expected none",
                             bus_if.pix_x, bus_if.pix_y, bus_if.pix_iter);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    if (bus_if.pix_x !== e.x || bus_if.pix_y !== e.y ||
                        bus_if.pix_iter !== e.iter) begin
                        n_fail++;
                        $display("FAIL pix_stream: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                                 bus_if.pix_x, bus_if.pix_y, bus_if.pix_iter,
                                 e.x, e.y, e.iter);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_issue_valid", bus_if.issue_valid, 0);
        check("rst_issue_x", bus_if.issue_x, 0);
        check("rst_pix_valid", bus_if.pix_valid, 0);
        check("rst_pix_iter", bus_if.pix_iter, 0);

        // Frame 1: 1-deep ring, imax=5, plus an ignored start while busy
        ring_en   = 1'b1;
        drv_esc   = 1'b0;
        drv_ready = 1'b1;
        push_frame(8'd5);
        imax  = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("f1_busy", busy, 1);
        repeat (10) tick();
        imax  = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("f1_restart_busy", busy, 1);
        check("f1_imax_kept", dut.imax_q, 5);
        wait_frames(1, "f1_frame_done");
        repeat (3) tick();
        check("f1_single_pulse", fd_count, 1);
        check("f1_idle", busy, 0);
        check("f1_all_retired", exp_q.size(), 0);

        // Frame 2: directed slots, imax=2
        ring_en   = 1'b0;
        drv_valid = 1'b0;
        drv_ready = 1'b0;
        imax  = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("f2_new0_valid", bus_if.issue_valid, 1);
        check("f2_new0_new", bus_if.issue_new, 1);
        check("f2_new0_x", bus_if.issue_x, 0);
        check("f2_new0_y", bus_if.issue_y, 0);
        check("f2_new0_iter", bus_if.issue_iter, 0);
        tick();
        check("f2_new1_x", bus_if.issue_x, 1);
        check("f2_new1_new", bus_if.issue_new, 1);
        tick();
        check("f2_new2_x", bus_if.issue_x, 2);
        check("f2_inflight3", dut.inflight_q, 3);

        // Finished (iter==imax) with output free: retire and refill
        exp_q.push_back('{x: 11'd0, y: 11'd0, iter: 8'd2});
        drv_valid = 1'b1; drv_x = 11'd0; drv_y = 11'd0; drv_iter = 8'd2; drv_esc = 1'b0;
        tick();
        check("f2_ret_pix_valid", bus_if.pix_valid, 1);
        check("f2_ret_pix_x", bus_if.pix_x, 0);
        check("f2_ret_pix_iter", bus_if.pix_iter, 2);
        check("f2_ret_refill_new", bus_if.issue_new, 1);
        check("f2_ret_refill_x", bus_if.issue_x, 3);

        // Escaped slot while output stalled: held for 4 cycles
        exp_q.push_back('{x: 11'd1, y: 11'd0, iter: 8'd0});
        drv_x = 11'd1; drv_y = 11'd0; drv_iter = 8'd0; drv_esc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("f2_hold_valid", bus_if.issue_valid, 1);
            check("f2_hold_flag", bus_if.issue_hold, 1);
            check("f2_hold_new", bus_if.issue_new, 0);
            check("f2_hold_x", bus_if.issue_x, 1);
            check("f2_hold_iter", bus_if.issue_iter, 0);
            check("f2_hold_pix_x", bus_if.pix_x, 0);
            check("f2_hold_pix_iter", bus_if.pix_iter, 2);
        end
        drv_ready = 1'b1;
        tick();
        check("f2_cap_pix_x", bus_if.pix_x, 1);
        check("f2_cap_pix_iter", bus_if.pix_iter, 0);
        check("f2_cap_refill_new", bus_if.issue_new, 1);
        check("f2_cap_refill_x", bus_if.issue_x, 0);
        check("f2_cap_refill_y", bus_if.issue_y, 1);
        drv_valid = 1'b0;
        drv_esc   = 1'b0;
        tick();
        tick();
        check("f2_inflight5", dut.inflight_q, 5);
        check("f2_busy", busy, 1);

        // Reset mid-frame, loop_valid held high across it
        drv_valid = 1'b1; drv_x = 11'd3; drv_y = 11'd1; drv_iter = 8'd0;
        rst = 1'b1;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_issue_valid", bus_if.issue_valid, 0);
        check("midrst_pix_valid", bus_if.pix_valid, 0);
        rst = 1'b0;
        tick();
        check("postrst_issue_valid", bus_if.issue_valid, 0);
        check("postrst_no_retire", bus_if.pix_valid, 0);

        // Frame 3: imax=0, every pixel retires on first return
        drv_valid = 1'b0;
        drv_esc   = 1'b0;
        drv_ready = 1'b1;
        push_frame(8'd0);
        imax  = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("f3_restart_new", bus_if.issue_new, 1);
        check("f3_restart_x", bus_if.issue_x, 0);
        check("f3_restart_y", bus_if.issue_y, 0);
        ring_en = 1'b1;
        wait_frames(2, "f3_frame_done");
        repeat (3) tick();
        check("f3_all_retired", exp_q.size(), 0);
        check("f3_pix_idle", bus_if.pix_valid, 0);
        check("f3_done_count", fd_count, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
